cam_init_seq: RTL
=================

Name: cam_init_seq

Overview:
- Table-driven camera register initialiser, successor to the fixed 8-write camera init sequencer.
- Walks a NUM_REGS-entry {sub_addr, data} table supplied through an external ROM port.
- Issues one register write per entry to the shared I2C/SCCB master (ena/busy/ack_err handshake).
- Retries NACKed writes, inserts a programmable inter-write gap, and reports done/error status to the top-level control.

Parameters:
NUM_REGS, 8, number of table entries written per run (1..256)
IDX_W, 8, width of table index (must satisfy 2**IDX_W >= NUM_REGS)
DEV_ADDR, 8'hC0, 8-bit device write address driven on addr
MAX_RETRY, 3, extra attempts per entry after a NACK (0 = no retry)
GAP_CYCLES, 16, idle clk cycles between consecutive transactions (0 allowed)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  level input; a rising edge launches a run
tbl_idx  out  IDX_W  current table index
tbl_sub_addr  in  8  register address at tbl_idx (combinational ROM, valid same cycle)
tbl_data  in  8  register value at tbl_idx
ena  out  1  transaction request to I2C master
addr  out  8  device address
sub_addr  out  8  register address
data_wr  out  8  write data
rw  out  1  0 = write, 1 = read
data_rd  in  8  read data from master
busy  in  1  master busy
ack_err  in  1  master NACK flag, valid when busy falls
seq_busy  out  1  run in progress
done  out  1  sticky: all entries acknowledged
error  out  1  sticky: retries exhausted
err_idx  out  IDX_W  index of the failing entry

Behaviour:
- Reset values: all outputs 0, state IDLE, start-edge register 0.
- Start detect: start_q registered every cycle. A rising edge (start & ~start_q) in IDLE, DONE or ERR clears done/error/err_idx, sets tbl_idx=0 and retry counter=0, and enters LOAD. Edges arriving in any other state are ignored.
- LOAD (1 cycle): latch tbl_sub_addr/tbl_data into sub_addr/data_wr; addr=DEV_ADDR; rw=0 → REQ.
- REQ: ena=1. On the first cycle busy=1, drop ena the next cycle and go to WAIT. addr/sub_addr/data_wr stay stable from LOAD until WAIT exits.
- WAIT: hold until busy=0, then sample ack_err → CHECK.
- CHECK, ack_err=0:
  - Last entry (tbl_idx==NUM_REGS-1): → DONE.
  - Otherwise: tbl_idx+1, retry=0 → GAP.
- CHECK, ack_err=1:
  - retry<MAX_RETRY: retry+1 → GAP (same index).
  - Otherwise: err_idx=tbl_idx → ERR.
- GAP: count GAP_CYCLES cycles, then → LOAD. If GAP_CYCLES=0, go directly to LOAD.
- DONE: done=1, seq_busy=0. ERR: error=1, seq_busy=0. Both hold until the next start edge.
- seq_busy=1 in every state except IDLE, DONE and ERR.
- Latency per clean entry: 1 (LOAD) + REQ/WAIT duration + 1 (CHECK) + GAP_CYCLES.
- busy already high on entry to REQ: treated as acceptance; ena pulses for 1 cycle.
- rst mid-run: immediate return to IDLE, ena=0, no status flagged.
- Counters saturate and never wrap. tbl_idx never exceeds NUM_REGS-1.

Optional Feature:
- Macro CAM_INIT_VERIFY_EN.
- Defined:
  - After each acknowledged write, issue a read to the same sub_addr via VREQ/VWAIT (rw=1, same handshake).
  - Compare data_rd to the latched data_wr.
  - A mismatch or NACK on the read counts as a failed attempt: same retry/ERR rules, with the write re-issued.
  - The index advances only on a matched readback.
- Undefined: the verify states are absent, rw is tied to 0, and data_rd is unused.

Test Plan:
- NUM_REGS=3, table {11:04, 14:20, 39:40}, master always ACKs, start 0→1 → three transactions with sub_addr/data exactly as listed, addr=C0. Consecutive ena pulses separated by ≥16 idle cycles. done=1, error=0, seq_busy=0.
- Master NACKs entry 1 twice, then ACKs (MAX_RETRY=3) → entry 1 sent 3 times, entry 2 follows, done=1.
- Master NACKs entry 2 four times → 4 attempts on entry 2, then error=1, err_idx=2, done=0, no further ena.
- rst pulse while in WAIT on entry 1 → all outputs 0 the next cycle. A later start edge restarts at tbl_idx=0.
- start held high after DONE, and a second edge issued mid-run → no restart while high, no effect mid-run. A fresh 0→1 after DONE restarts and clears done.
- With CAM_INIT_VERIFY_EN: data_rd returns 8'h05 for a write of 8'h04 with MAX_RETRY=0 → error=1, err_idx=0. With a correct readback, each entry shows one write followed by one read (rw=1).

Source files
------------

// File: rtl/cam_init_seq.sv
// cam_init_seq: table-driven camera register initialiser.
// Walks a NUM_REGS-entry {sub_addr, data} ROM and issues one write per entry
// to the shared I2C/SCCB master over the ena/busy/ack_err handshake, with
// per-entry NACK retry, a programmable inter-write gap and sticky done/error.
// Optional feature: define CAM_INIT_VERIFY_EN to read back each acknowledged
// write and treat a NACK or data mismatch on the readback as a failed attempt.
module cam_init_seq #(
    parameter int          NUM_REGS   = 8,
    parameter int          IDX_W      = 8,
    parameter logic [7:0]  DEV_ADDR   = 8'hC0,
    parameter int          MAX_RETRY  = 3,
    parameter int          GAP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [7:0]       tbl_sub_addr,
    input  logic [7:0]       tbl_data,
    output logic             ena,
    output logic [7:0]       addr,
    output logic [7:0]       sub_addr,
    output logic [7:0]       data_wr,
    output logic             rw,
    input  logic [7:0]       data_rd,
    input  logic             busy,
    input  logic             ack_err,
    output logic             seq_busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] err_idx
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_CHECK,
        S_GAP,
        S_DONE,
`ifdef CAM_INIT_VERIFY_EN
        S_ERR,
        S_VREQ,
        S_VWAIT
`else
        S_ERR
`endif
    } state_t;

    // Where a retry or an index advance goes next: straight to LOAD when no gap.
    localparam state_t S_AFTER = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;

    state_t             state;
    logic               start_q;
    logic               start_edge;
    logic [RETRY_W-1:0] retry_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               ack_q;
`ifdef CAM_INIT_VERIFY_EN
    logic               verify_ph;
`else
    logic               unused_data_rd;

    assign rw             = 1'b0;
    assign unused_data_rd = ^data_rd;
`endif

    assign start_edge = start & ~start_q;

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            retry_cnt <= '0;
            gap_cnt   <= '0;
            ack_q     <= 1'b0;
            tbl_idx   <= '0;
            ena       <= 1'b0;
            addr      <= '0;
            sub_addr  <= '0;
            data_wr   <= '0;
            seq_busy  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_idx   <= '0;
`ifdef CAM_INIT_VERIFY_EN
            rw        <= 1'b0;
            verify_ph <= 1'b0;
`endif
        end else begin
            start_q <= start;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_edge) begin
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_idx   <= '0;
                        tbl_idx   <= '0;
                        retry_cnt <= '0;
                        seq_busy  <= 1'b1;
                        state     <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    addr     <= DEV_ADDR;
                    sub_addr <= tbl_sub_addr;
                    data_wr  <= tbl_data;
                    ena      <= 1'b1;
`ifdef CAM_INIT_VERIFY_EN
                    rw        <= 1'b0;
                    verify_ph <= 1'b0;
`endif
                    state    <= S_REQ;
                end

                S_REQ: begin
                    if (busy) begin
                        ena   <= 1'b0;
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (!busy) begin
                        ack_q <= ack_err;
                        state <= S_CHECK;
                    end
                end

`ifdef CAM_INIT_VERIFY_EN
                S_VREQ: begin
                    if (busy) begin
                        ena   <= 1'b0;
                        state <= S_VWAIT;
                    end
                end

                // A readback mismatch is folded into the ack flag so CHECK
                // applies the same retry/ERR rules as a NACKed write.
                S_VWAIT: begin
                    if (!busy) begin
                        ack_q     <= ack_err | (data_rd != data_wr);
                        verify_ph <= 1'b1;
                        state     <= S_CHECK;
                    end
                end
`endif

                S_CHECK: begin
                    if (ack_q) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            gap_cnt   <= '0;
                            state     <= S_AFTER;
                        end else begin
                            err_idx  <= tbl_idx;
                            error    <= 1'b1;
                            seq_busy <= 1'b0;
                            state    <= S_ERR;
                        end
                    end
`ifdef CAM_INIT_VERIFY_EN
                    else if (!verify_ph) begin
                        rw    <= 1'b1;
                        ena   <= 1'b1;
                        state <= S_VREQ;
                    end
`endif
                    else if (tbl_idx == LAST_IDX) begin
                        done     <= 1'b1;
                        seq_busy <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        tbl_idx   <= tbl_idx + IDX_W'(1);
                        retry_cnt <= '0;
                        gap_cnt   <= '0;
                        state     <= S_AFTER;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
